// File: rtl/transfer_pkg.sv
// Shared constants, FSM state type and packet-layout helper for the transfer_tx serializer.
package transfer_pkg;

  localparam int unsigned PKT_BYTES    = 12;
  localparam int unsigned SRC_OFS      = 0;
  localparam int unsigned DST_OFS      = 4;
  localparam int unsigned AMT_OFS      = 8;
  localparam int unsigned PREAMBLE_LEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_SEND   = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_REJECT = 3'd5
  } tx_state_t;

  // Byte 0 of the packet sits in bits [95:88] so the serializer can shift left.
  function automatic logic [95:0] pack_pkt(input logic [31:0] src,
                                           input logic [31:0] dst,
                                           input logic [31:0] amt);
    logic [95:0] p;
    p = 96'd0;
    p[95 - 8*SRC_OFS -: 32] = src;
    p[95 - 8*DST_OFS -: 32] = dst;
    p[95 - 8*AMT_OFS -: 32] = amt;
    return p;
  endfunction

endpackage

// File: rtl/transfer_tx_pacer.sv
// Byte-gap down-counter for transfer_tx: load arms BYTE_GAP-1, expire flags a count of zero.
module transfer_tx_pacer
  import transfer_pkg::*;
#(
  parameter int unsigned BYTE_GAP = 4
) (
  input  logic tick_in,
  input  logic rst,
  input  logic load_i,
  output logic expire_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: reload on a toggle, otherwise run down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 8'(BYTE_GAP - 1);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge tick_in) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 8'd0);

endmodule

// File: rtl/transfer_tx.sv
// Top of the 12-byte transfer packet serializer (toggle-strobed byte link).
// Optional two-byte preamble ahead of the data when TRANSFER_TX_PREAMBLE_EN is defined.
module transfer_tx
  import transfer_pkg::*;
#(
  parameter int unsigned BYTE_GAP = 4
) (
  input  logic        tick_in,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] src_key,
  input  logic [31:0] dst_key,
  input  logic [31:0] amount,
  output logic [7:0]  byte_o,
  output logic        newbyt,
  output logic        busy,
  output logic        done,
  output logic        err
);

  tx_state_t   state_q;
  tx_state_t   state_d;
  logic [95:0] shift_q;
  logic [95:0] pkt_s;
  logic [3:0]  idx_q;
  logic [7:0]  byte_q;
  logic        newbyt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        req_ready_q;
  logic        hs_s;
  logic        reject_s;
  logic        load_pkt_s;
  logic        more_s;
  logic        emit_pre_s;
  logic        emit_data_s;
  logic        gap_expire_s;
`ifdef TRANSFER_TX_PREAMBLE_EN
  logic [1:0]  pre_cnt_q;
`endif

  assign hs_s       = req_valid & req_ready_q;
  assign reject_s   = hs_s & (src_key == dst_key);
  assign load_pkt_s = hs_s & ~reject_s;
  assign more_s     = (idx_q < 4'(PKT_BYTES));
  // On the handshake cycle the first byte comes straight from the inputs.
  assign pkt_s      = load_pkt_s ? pack_pkt(src_key, dst_key, amount) : shift_q;

  transfer_tx_pacer #(
    .BYTE_GAP (BYTE_GAP)
  ) u_pacer (
    .tick_in  (tick_in),
    .rst      (rst),
    .load_i   (emit_pre_s | emit_data_s),
    .expire_o (gap_expire_s)
  );

  // Next state and per-cycle emit decisions; every toggle happens on entry to PRE or SEND.
  always_comb begin
    state_d     = state_q;
    emit_pre_s  = 1'b0;
    emit_data_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reject_s) begin
          state_d = ST_REJECT;
        end else if (hs_s) begin
`ifdef TRANSFER_TX_PREAMBLE_EN
          state_d    = ST_PRE;
          emit_pre_s = 1'b1;
`else
          state_d     = ST_SEND;
          emit_data_s = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
`ifdef TRANSFER_TX_PREAMBLE_EN
        if (!gap_expire_s) begin
          state_d = ST_PRE;
        end else if (pre_cnt_q < 2'(PREAMBLE_LEN)) begin
          state_d    = ST_PRE;
          emit_pre_s = 1'b1;
        end else begin
          state_d     = ST_SEND;
          emit_data_s = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_SEND, ST_GAP: begin
        if (!gap_expire_s) begin
          state_d = ST_GAP;
        end else if (more_s) begin
          state_d     = ST_SEND;
          emit_data_s = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register and status outputs, all registered from the next state.
  always_ff @(posedge tick_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE) && (state_d != ST_REJECT);
      done_q      <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_REJECT);
    end
  end

  // Byte datapath: shift register, byte index and the toggle strobe.
  always_ff @(posedge tick_in) begin
    if (rst) begin
      shift_q  <= 96'd0;
      idx_q    <= 4'd0;
      byte_q   <= 8'h00;
      newbyt_q <= 1'b0;
    end else begin
      newbyt_q <= newbyt_q ^ (emit_pre_s | emit_data_s);
      if (emit_data_s) begin
        byte_q  <= pkt_s[95:88];
        shift_q <= {pkt_s[87:0], 8'h00};
      end else if (emit_pre_s) begin
        byte_q  <= 8'h00;
        shift_q <= pkt_s;
      end else begin
        byte_q  <= byte_q;
        shift_q <= shift_q;
      end
      if (load_pkt_s) begin
        idx_q <= {3'd0, emit_data_s};
      end else if (emit_data_s) begin
        idx_q <= idx_q + 4'd1;
      end else begin
        idx_q <= idx_q;
      end
    end
  end

`ifdef TRANSFER_TX_PREAMBLE_EN
  // Counts preamble toggles already sent for the current packet.
  always_ff @(posedge tick_in) begin
    if (rst) begin
      pre_cnt_q <= 2'd0;
    end else if (load_pkt_s) begin
      pre_cnt_q <= {1'b0, emit_pre_s};
    end else if (emit_pre_s) begin
      pre_cnt_q <= pre_cnt_q + 2'd1;
    end else begin
      pre_cnt_q <= pre_cnt_q;
    end
  end
`endif

  assign req_ready = req_ready_q;
  assign byte_o    = byte_q;
  assign newbyt    = newbyt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_transfer_tx.sv
// Bench for transfer_tx: instances with BYTE_GAP 1 and 4, each cycle compared against an
// arithmetic schedule of toggles/bytes derived from the handshake cycle.
module tb_transfer_tx;

  localparam int GAP_A = 1;
  localparam int GAP_B = 4;
`ifdef TRANSFER_TX_PREAMBLE_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif
  localparam int NDATA = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][31:0] src_k;
  logic [1:0][31:0] dst_k;
  logic [1:0][31:0] amt_v;
  logic [1:0]       req_ready;
  logic [1:0]       newbyt;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       err;
  logic [1:0][7:0]  byte_w;

  int   total = 0;
  int   bad   = 0;
  logic [7:0] last_byte [2];
  logic       last_nb   [2];

  always #5 clk = ~clk;

  transfer_tx #(.BYTE_GAP(GAP_A)) u_dut_a (
    .tick_in(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .src_key(src_k[0]), .dst_key(dst_k[0]), .amount(amt_v[0]), .byte_o(byte_w[0]),
    .newbyt(newbyt[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  transfer_tx #(.BYTE_GAP(GAP_B)) u_dut_b (
    .tick_in(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .src_key(src_k[1]), .dst_key(dst_k[1]), .amount(amt_v[1]), .byte_o(byte_w[1]),
    .newbyt(newbyt[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic string tg(input string nm, input int i, input int t);
    return $sformatf("%s[dut%0d t=%0d]", nm, i, t);
  endfunction

  // Packet byte j (0..11): big-endian src, dst, amount.
  function automatic logic [7:0] model_byte(input logic [31:0] s, input logic [31:0] d,
                                            input logic [31:0] a, input int j);
    logic [31:0] f;
    if (j < 4) f = s;
    else if (j < 8) f = d;
    else f = a;
    return 8'((f >> (8 * (3 - (j % 4)))) & 32'hFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input int i, input string nm);
    chk(tg({nm, "_byte"}, i, 0), 32'(byte_w[i]), 32'h0);
    chk(tg({nm, "_newbyt"}, i, 0), 32'(newbyt[i]), 32'h0);
    chk(tg({nm, "_busy"}, i, 0), 32'(busy[i]), 32'h0);
    chk(tg({nm, "_done"}, i, 0), 32'(done[i]), 32'h0);
    chk(tg({nm, "_err"}, i, 0), 32'(err[i]), 32'h0);
    chk(tg({nm, "_ready"}, i, 0), 32'(req_ready[i]), 32'h0);
  endtask

  // Called at the negedge of handshake cycle 0; checks cycles 1..end (or 1..t_stop).
  task automatic run_window(input int i, input bit rej, input logic [31:0] s,
                            input logic [31:0] d, input logic [31:0] a, input bit hold,
                            input logic [31:0] ns, input logic [31:0] nd,
                            input logic [31:0] na, input int t_stop);
    int g, n, nt, last, tend;
    logic [7:0] eb;
    logic en;
    g    = gap_of(i);
    nt   = rej ? 0 : PRE + NDATA;
    last = 1 + nt * g;
    tend = rej ? 2 : last + 1;
    if (t_stop > 0) tend = t_stop;
    eb = last_byte[i];
    en = last_nb[i];
    for (int t = 1; t <= tend; t++) begin
      @(negedge clk);
      if (t == 1) begin
        req_valid[i] = hold;
        src_k[i] = hold ? ns : $urandom;
        dst_k[i] = hold ? nd : $urandom;
        amt_v[i] = hold ? na : $urandom;
      end
      n = rej ? 0 : (t - 1) / g + 1;
      if (n > nt) n = nt;
      en = last_nb[i] ^ n[0];
      if (n == 0) eb = last_byte[i];
      else if (n <= PRE) eb = 8'h00;
      else eb = model_byte(s, d, a, n - PRE - 1);
      chk(tg("newbyt", i, t), 32'(newbyt[i]), 32'(en));
      chk(tg("byte", i, t), 32'(byte_w[i]), 32'(eb));
      if (rej) begin
        chk(tg("err", i, t), 32'(err[i]), 32'(t == 1));
        chk(tg("busy", i, t), 32'(busy[i]), 32'h0);
        chk(tg("done", i, t), 32'(done[i]), 32'h0);
        chk(tg("ready", i, t), 32'(req_ready[i]), 32'(t >= 2));
      end else begin
        chk(tg("err", i, t), 32'(err[i]), 32'h0);
        chk(tg("busy", i, t), 32'(busy[i]), 32'(t <= last));
        chk(tg("done", i, t), 32'(done[i]), 32'(t == last));
        chk(tg("ready", i, t), 32'(req_ready[i]), 32'(t > last));
      end
    end
    last_byte[i] = eb;
    last_nb[i]   = en;
  endtask

  task automatic send(input int i, input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] a);
    req_valid[i] = 1'b1;
    src_k[i] = s;
    dst_k[i] = d;
    amt_v[i] = a;
    run_window(i, s == d, s, d, a, 1'b0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  initial begin
    logic [31:0] rs, rd, ra;
    rst       = 1'b1;
    req_valid = 2'b00;
    src_k     = '0;
    dst_k     = '0;
    amt_v     = '0;
    for (int i = 0; i < 2; i++) begin
      last_byte[i] = 8'h00;
      last_nb[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk_idle_reset(i, "in_reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk(tg("ready_after_reset", i, 0), 32'(req_ready[i]), 32'h1);

    // Directed packet on both pacings, then a rejected request.
    for (int i = 0; i < 2; i++) begin
      send(i, 32'h0000_0005, 32'h0000_0009, 32'h0000_0064);
      send(i, 32'h0000_000A, 32'h0000_000A, 32'h1234_5678);
    end

    // Request held valid across a packet: second one taken the cycle after done.
    req_valid[0] = 1'b1;
    src_k[0] = 32'hA1B2_C3D4;
    dst_k[0] = 32'h0102_0304;
    amt_v[0] = 32'hFFFF_0000;
    run_window(0, 1'b0, 32'hA1B2_C3D4, 32'h0102_0304, 32'hFFFF_0000, 1'b1,
               32'h5566_7788, 32'h99AA_BBCC, 32'h0000_0000, 0);
    run_window(0, 1'b0, 32'h5566_7788, 32'h99AA_BBCC, 32'h0000_0000, 1'b0,
               32'd0, 32'd0, 32'd0, 0);

    // Randomized requests, including zero amounts and occasional rejects.
    for (int r = 0; r < 6; r++) begin
      rs = $urandom;
      rd = $urandom;
      ra = (r == 2) ? 32'd0 : $urandom;
      if (rd == rs) rd = ~rs;
      if (r == 4) rd = rs;
      send(r % 2, rs, rd, ra);
    end

    // Reset right after the 6th toggle on the slow instance aborts the packet.
    req_valid[1] = 1'b1;
    src_k[1] = 32'hDEAD_BEEF;
    dst_k[1] = 32'hCAFE_F00D;
    amt_v[1] = 32'h0BAD_F00D;
    run_window(1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D, 1'b0,
               32'd0, 32'd0, 32'd0, 1 + 5 * GAP_B);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_idle_reset(i, "abort");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_byte[i] = 8'h00;
      last_nb[i]   = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(tg("ready_after_abort", i, 0), 32'(req_ready[i]), 32'h1);
      chk(tg("done_after_abort", i, 0), 32'(done[i]), 32'h0);
    end
    send(1, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    send(0, 32'h7777_8888, 32'h9999_AAAA, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
